// File: rtl/ufm_flash_responder.sv
// rtl/ufm_flash_responder.sv - flash external-interface responder onto UFM data and CSR ports
// Strobes are flops loaded from the next state; EI_ACK is a flop loaded from the ACK state.
module ufm_flash_responder #(
   parameter int DATA_AW = 17,
   parameter int TIMEOUT = 1023
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [23:0]        EI_ADDR,
   input  logic               EI_READ,
   input  logic               EI_WRITE,
   input  logic [31:0]        EI_WDATA,
   input  logic [3:0]         EI_BE,
   output logic [31:0]        EI_RDATA,
   output logic               EI_ACK,
   output logic [DATA_AW-1:0] DATA_ADDR,
   output logic               DATA_READ,
   output logic               DATA_WRITE,
   output logic [31:0]        DATA_WDATA,
   input  logic [31:0]        DATA_RDATA,
   input  logic               DATA_WAITREQ,
   input  logic               DATA_RDVALID,
   output logic               CSR_ADDR,
   output logic               CSR_READ,
   output logic               CSR_WRITE,
   output logic [31:0]        CSR_WDATA,
   input  logic [31:0]        CSR_RDATA
);

   typedef enum logic [2:0] {
      S_IDLE, S_DRD, S_DRV, S_DWR, S_CSR, S_CSRD, S_ACK, S_HOLD
   } state_t;

   // The counter has already counted this cycle when it lands on TIMEOUT.
   localparam logic [10:0] TO_LAST = 11'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic        is_rd, rd_nxt;
   logic [10:0] cnt;
   logic        hit_data, hit_csr, accept, busy, timeout;
   logic        data_read_d, data_write_d, csr_read_d, csr_write_d;
   logic        rdata_en;
   logic [31:0] rdata_d;
   logic        unused_addr_lsb;

   assign hit_data        = (EI_ADDR[23:19] == 5'd0);
   assign hit_csr         = (EI_ADDR[23:3] == 21'h010000);
   assign accept          = (state == S_IDLE) && (EI_READ || EI_WRITE);
   assign busy            = (state == S_DRD) || (state == S_DRV) || (state == S_DWR);
   assign timeout         = busy && (cnt == TO_LAST);
   assign unused_addr_lsb = &{1'b0, EI_ADDR[1:0]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         is_rd      <= 1'b0;
         cnt        <= 11'd0;
         EI_RDATA   <= 32'd0;
         EI_ACK     <= 1'b0;
         DATA_ADDR  <= '0;
         DATA_READ  <= 1'b0;
         DATA_WRITE <= 1'b0;
         DATA_WDATA <= 32'd0;
         CSR_ADDR   <= 1'b0;
         CSR_READ   <= 1'b0;
         CSR_WRITE  <= 1'b0;
         CSR_WDATA  <= 32'd0;
      end else begin
         state      <= state_nxt;
         is_rd      <= rd_nxt;
         DATA_READ  <= data_read_d;
         DATA_WRITE <= data_write_d;
         CSR_READ   <= csr_read_d;
         CSR_WRITE  <= csr_write_d;
         EI_ACK     <= (state == S_ACK);
         if (state == S_IDLE)
            cnt <= 11'd0;
         else if (busy)
            cnt <= cnt + 11'd1;
         if (accept && hit_data) begin
            DATA_ADDR  <= EI_ADDR[DATA_AW+1:2];
            DATA_WDATA <= EI_WDATA;
         end
         if (accept && hit_csr) begin
            CSR_ADDR  <= EI_ADDR[2];
            CSR_WDATA <= EI_WDATA;
         end
         if (rdata_en)
            EI_RDATA <= rdata_d;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (accept) begin
               if (hit_data) begin
                  if (EI_READ)
                     state_nxt = S_DRD;
                  else if (EI_BE == 4'hF)
                     state_nxt = S_DWR;
                  else
                     state_nxt = S_ACK;
               end else if (hit_csr) begin
                  state_nxt = S_CSR;
               end else begin
                  state_nxt = S_ACK;
               end
            end
         S_DRD:  if (timeout) state_nxt = S_ACK;
                 else if (!DATA_WAITREQ) state_nxt = S_DRV;
         S_DRV:  if (DATA_RDVALID || timeout) state_nxt = S_ACK;
         S_DWR:  if (!DATA_WAITREQ || timeout) state_nxt = S_ACK;
         S_CSR:  state_nxt = is_rd ? S_CSRD : S_ACK;
         S_CSRD: state_nxt = S_ACK;
         S_ACK:  state_nxt = S_HOLD;
         S_HOLD: if (!EI_READ && !EI_WRITE) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      rd_nxt       = accept ? EI_READ : is_rd;
      data_read_d  = (state_nxt == S_DRD);
      data_write_d = (state_nxt == S_DWR);
      csr_read_d   = (state_nxt == S_CSR) && rd_nxt;
      csr_write_d  = (state_nxt == S_CSR) && !rd_nxt;
      rdata_en     = 1'b0;
      rdata_d      = DATA_RDATA;
      case (state)
         S_IDLE:
            if (accept && !hit_data && !hit_csr && EI_READ) begin
               rdata_en = 1'b1;
               rdata_d  = 32'hFFFF_FFFF;
            end
         S_DRD:
            if (timeout) begin
               rdata_en = 1'b1;
               rdata_d  = 32'hFFFF_FFFF;
            end
         S_DRV:
            if (DATA_RDVALID) begin
               rdata_en = 1'b1;
               rdata_d  = DATA_RDATA;
            end else if (timeout) begin
               rdata_en = 1'b1;
               rdata_d  = 32'hFFFF_FFFF;
            end
         S_CSRD: begin
            rdata_en = 1'b1;
            rdata_d  = CSR_RDATA;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ufm_flash_responder.sv
// tb/tb_ufm_flash_responder.sv - directed and random transactions against a transaction-level model
module tb_ufm_flash_responder;

   localparam int TMO = 15;

   logic        CLK = 1'b0;
   logic        RST;
   logic [23:0] EI_ADDR;
   logic        EI_READ, EI_WRITE;
   logic [31:0] EI_WDATA;
   logic [3:0]  EI_BE;
   logic [31:0] EI_RDATA;
   logic        EI_ACK;
   logic [16:0] DATA_ADDR;
   logic        DATA_READ, DATA_WRITE;
   logic [31:0] DATA_WDATA, DATA_RDATA;
   logic        DATA_WAITREQ, DATA_RDVALID;
   logic        CSR_ADDR, CSR_READ, CSR_WRITE;
   logic [31:0] CSR_WDATA, CSR_RDATA;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_rd = 32'd0;

   always #5 CLK = ~CLK;

   ufm_flash_responder #(.DATA_AW(17), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST(RST),
      .EI_ADDR(EI_ADDR), .EI_READ(EI_READ), .EI_WRITE(EI_WRITE),
      .EI_WDATA(EI_WDATA), .EI_BE(EI_BE), .EI_RDATA(EI_RDATA), .EI_ACK(EI_ACK),
      .DATA_ADDR(DATA_ADDR), .DATA_READ(DATA_READ), .DATA_WRITE(DATA_WRITE),
      .DATA_WDATA(DATA_WDATA), .DATA_RDATA(DATA_RDATA),
      .DATA_WAITREQ(DATA_WAITREQ), .DATA_RDVALID(DATA_RDVALID),
      .CSR_ADDR(CSR_ADDR), .CSR_READ(CSR_READ), .CSR_WRITE(CSR_WRITE),
      .CSR_WDATA(CSR_WDATA), .CSR_RDATA(CSR_RDATA)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic any_out();
      return |{EI_ACK, DATA_ADDR, DATA_READ, DATA_WRITE, DATA_WDATA,
               CSR_ADDR, CSR_READ, CSR_WRITE, CSR_WDATA};
   endfunction

   // Called at #1 after an edge with the responder idle; w = wait-request cycles,
   // d = extra cycles before read-data-valid, hold_n = cycles the request stays up after ack.
   task automatic run_txn(input string tag, input logic [23:0] addr, input logic rd, input logic wr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int w, input int d, input int hold_n,
                          input logic [31:0] dval, input logic [31:0] cval);
      int          exp_ack, exp_dr, exp_dw, exp_cr, exp_cw;
      logic [31:0] exp_rd;
      logic [16:0] exp_da;
      logic        exp_ca, is_data, is_csr, slave_rd, csr_pend;
      int          ack_at, n_ack, n_dr, n_dw, n_cr, n_cw, n_bad, drop_at;
      logic [31:0] rd_at_ack;

      is_data = (addr < 24'h080000);
      is_csr  = (addr >= 24'h080000) && (addr <= 24'h080007);
      exp_da  = 17'(addr / 4);
      exp_ca  = is_csr && ((addr - 24'h080000) >= 4);
      exp_dr = 0; exp_dw = 0; exp_cr = 0; exp_cw = 0; exp_ack = 1;
      exp_rd = last_rd;
      if (is_data && rd) begin
         if (w + 1 >= TMO) begin
            exp_dr = TMO; exp_ack = TMO + 1; exp_rd = 32'hFFFF_FFFF;
         end else if (w + d + 2 > TMO) begin
            exp_dr = w + 1; exp_ack = TMO + 1; exp_rd = 32'hFFFF_FFFF;
         end else begin
            exp_dr = w + 1; exp_ack = w + d + 3; exp_rd = dval;
         end
      end else if (is_data && be == 4'hF) begin
         exp_dw  = (w + 1 < TMO) ? w + 1 : TMO;
         exp_ack = exp_dw + 1;
      end else if (is_csr && rd) begin
         exp_cr = 1; exp_ack = 3; exp_rd = cval;
      end else if (is_csr) begin
         exp_cw = 1; exp_ack = 2;
      end else if (rd) begin
         exp_rd = 32'hFFFF_FFFF;
      end
      last_rd  = exp_rd;
      slave_rd = is_data && rd;

      EI_ADDR = addr; EI_READ = rd; EI_WRITE = wr; EI_WDATA = wdata; EI_BE = be;
      ack_at = -1; drop_at = -1; n_ack = 0; n_dr = 0; n_dw = 0; n_cr = 0; n_cw = 0; n_bad = 0;
      rd_at_ack = 32'd0; csr_pend = 1'b0;
      for (int c = 0; c < 70; c++) begin
         @(posedge CLK); #1;
         if (DATA_READ) begin n_dr++; if (DATA_ADDR !== exp_da) n_bad++; end
         if (DATA_WRITE) begin n_dw++; if (DATA_ADDR !== exp_da || DATA_WDATA !== wdata) n_bad++; end
         if (CSR_READ) begin n_cr++; if (CSR_ADDR !== exp_ca) n_bad++; end
         if (CSR_WRITE) begin n_cw++; if (CSR_ADDR !== exp_ca || CSR_WDATA !== wdata) n_bad++; end
         if (EI_ACK) begin
            n_ack++;
            if (ack_at < 0) begin ack_at = c; rd_at_ack = EI_RDATA; end
         end
         if (c == 0) begin EI_ADDR = 24'($urandom); EI_WDATA = $urandom; EI_BE = 4'($urandom); end
         DATA_WAITREQ = (c < w);
         DATA_RDVALID = slave_rd && (c == w + 1 + d);
         DATA_RDATA   = DATA_RDVALID ? dval : $urandom;
         CSR_RDATA    = csr_pend ? cval : $urandom;
         csr_pend     = CSR_READ;
         if (drop_at < 0 && ack_at >= 0 && c >= ack_at + hold_n) begin
            EI_READ = 1'b0; EI_WRITE = 1'b0; drop_at = c;
         end
         if (drop_at >= 0 && c >= drop_at + 4) break;
      end
      DATA_RDVALID = 1'b0;
      if (drop_at < 0) begin
         EI_READ = 1'b0; EI_WRITE = 1'b0;
         repeat (4) begin @(posedge CLK); #1; end
      end
      chk({tag, ":ack_cycle"}, ack_at, exp_ack);
      chk({tag, ":ack_count"}, n_ack, 1);
      chk({tag, ":data_read_cycles"}, n_dr, exp_dr);
      chk({tag, ":data_write_cycles"}, n_dw, exp_dw);
      chk({tag, ":csr_read_cycles"}, n_cr, exp_cr);
      chk({tag, ":csr_write_cycles"}, n_cw, exp_cw);
      chk({tag, ":port_addr_wdata"}, n_bad, 0);
      chk({tag, ":rdata_at_ack"}, rd_at_ack, exp_rd);
      chk({tag, ":rdata_held"}, EI_RDATA, exp_rd);
   endtask

   initial begin
      int seen;
      logic [23:0] a;
      logic        r, wr;
      logic [3:0]  be;

      RST = 1'b1; EI_ADDR = '0; EI_READ = 1'b0; EI_WRITE = 1'b0; EI_WDATA = '0; EI_BE = '0;
      DATA_RDATA = '0; DATA_WAITREQ = 1'b1; DATA_RDVALID = 1'b0; CSR_RDATA = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset:outputs", {31'd0, any_out()}, 32'd0);
      chk("reset:rdata", EI_RDATA, 32'd0);
      RST = 1'b0;
      @(posedge CLK); #1;

      run_txn("csr_rd_status", 24'h080004, 1, 0, 32'h0, 4'h0, 0, 0, 0, 32'h0, 32'h0000_0003);
      run_txn("data_rd_wait", 24'h000104, 1, 0, 32'h0, 4'hF, 2, 2, 0, 32'hDEAD_BEEF, 32'h0);
      run_txn("data_wr_top", 24'h07FFFC, 0, 1, 32'hA5A5_0F0F, 4'hF, 4, 0, 0, 32'h0, 32'h0);
      run_txn("data_wr_part", 24'h07FFFC, 0, 1, 32'h1234_5678, 4'h3, 4, 0, 0, 32'h0, 32'h0);
      run_txn("data_rd_held", 24'h000040, 1, 0, 32'h0, 4'hF, 1, 1, 20, 32'h0BAD_F00D, 32'h0);
      run_txn("unmapped_rd", 24'h100000, 1, 0, 32'h0, 4'hF, 0, 0, 0, 32'h0, 32'h0);
      run_txn("unmapped_wr", 24'h080008, 0, 1, 32'h5555_AAAA, 4'hF, 0, 0, 0, 32'h0, 32'h0);
      run_txn("timeout_drd", 24'h000010, 1, 0, 32'h0, 4'hF, 200, 0, 0, 32'h1111_1111, 32'h0);
      run_txn("timeout_drv", 24'h000020, 1, 0, 32'h0, 4'hF, 3, 30, 0, 32'h2222_2222, 32'h0);
      run_txn("csr_wr_ctrl", 24'h080007, 0, 1, 32'hC0DE_0001, 4'h1, 0, 0, 1, 32'h0, 32'h0);
      run_txn("rd_wr_both", 24'h000300, 1, 1, 32'h9999_9999, 4'hF, 0, 0, 2, 32'h7654_3210, 32'h0);

      // Reset while waiting for read data: no ack, late read-data-valid ignored.
      EI_ADDR = 24'h000200; EI_READ = 1'b1; DATA_WAITREQ = 1'b0; DATA_RDVALID = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      chk("rst_mid:in_drv_strobe", {31'd0, DATA_READ}, 32'd0);
      RST = 1'b1; EI_READ = 1'b0;
      @(posedge CLK); #1;
      chk("rst_mid:outputs", {31'd0, any_out()}, 32'd0);
      chk("rst_mid:rdata", EI_RDATA, 32'd0);
      RST = 1'b0; DATA_RDVALID = 1'b1; DATA_RDATA = 32'h1234_5678;
      seen = 0;
      repeat (6) begin
         @(posedge CLK); #1;
         DATA_RDVALID = 1'b0;
         if (any_out()) seen++;
      end
      chk("rst_mid:quiet_after", seen, 0);
      chk("rst_mid:rdata_held", EI_RDATA, 32'd0);
      last_rd = 32'd0;
      run_txn("csr_rd_after_rst", 24'h080000, 1, 0, 32'h0, 4'h0, 0, 0, 0, 32'h0, 32'h8000_0042);

      for (int i = 0; i < 25; i++) begin
         case ($urandom_range(0, 2))
            0:       a = 24'($urandom_range(0, 32'h07FFFF));
            1:       a = 24'h080000 + 24'($urandom_range(0, 7));
            default: a = 24'($urandom_range(32'h080008, 32'hFFFFFF));
         endcase
         case ($urandom_range(0, 2))
            0:       begin r = 1'b1; wr = 1'b0; end
            1:       begin r = 1'b0; wr = 1'b1; end
            default: begin r = 1'b1; wr = 1'b1; end
         endcase
         be = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 14));
         run_txn($sformatf("rand%0d", i), a, r, wr, $urandom, be,
                 $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                 $urandom, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
